// File: rtl/esc_ramp_sequencer.sv
// ESC spin-up sequencer: IDLE -> ALIGN -> RAMP -> RUN, with BRAKE spin-down.
// Define ESC_STALL_DETECT_EN to build the speed-feedback stall watchdog and FAULT state.
module esc_ramp_sequencer #(
    parameter int unsigned             DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0]   START_PERIOD = 16'd4000,
    parameter logic [DATA_WIDTH-1:0]   ALIGN_CYCLES = 16'd1000,
    parameter logic [DATA_WIDTH-1:0]   BRAKE_CYCLES = 16'd500,
    parameter logic [DATA_WIDTH-1:0]   SPEED_TOL    = 16'd8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  fault_clr,
    input  logic [DATA_WIDTH-1:0] target_period,
    input  logic [DATA_WIDTH-1:0] ramp_step,
    input  logic [DATA_WIDTH-1:0] ramp_interval,
    input  logic                  speed_update,
    input  logic [DATA_WIDTH-1:0] period_speed,
    input  logic [DATA_WIDTH-1:0] stall_limit,
    output logic                  pwm_en,
    output logic [DATA_WIDTH-1:0] period_reference,
    output logic                  busy,
    output logic                  at_speed,
    output logic                  fault,
    output logic [2:0]            state
);

    localparam int unsigned CW = DATA_WIDTH + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_RAMP  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_BRAKE = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_ref, w_ref_nxt;
    logic [DATA_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                  r_pwm_en, r_busy, r_at_speed;
    logic [CW-1:0]         w_cnt_inc, w_ref_x, w_tgt_x, w_step_x, w_diff, w_delta, w_ref_step;
    logic [CW-1:0]         w_spd_x, w_spd_diff;
    logic                  w_tick, w_stall, w_fault_clr, w_spd_ok;

    // Ramp arithmetic is one bit wider so the step can never wrap the reference.
    assign w_cnt_inc  = CW'(r_cnt) + CW'(1);
    assign w_ref_x    = CW'(r_ref);
    assign w_tgt_x    = CW'(target_period);
    assign w_step_x   = (ramp_step == '0) ? CW'(1) : CW'(ramp_step);
    assign w_diff     = (w_ref_x > w_tgt_x) ? (w_ref_x - w_tgt_x) : (w_tgt_x - w_ref_x);
    assign w_delta    = (w_step_x < w_diff) ? w_step_x : w_diff;
    assign w_tick     = (r_cnt >= ramp_interval);
    assign w_ref_step = !w_tick ? w_ref_x :
                        (w_ref_x > w_tgt_x) ? (w_ref_x - w_delta) : (w_ref_x + w_delta);

    assign w_spd_x    = CW'(period_speed);
    assign w_spd_diff = (w_spd_x > w_tgt_x) ? (w_spd_x - w_tgt_x) : (w_tgt_x - w_spd_x);
    assign w_spd_ok   = (w_spd_diff <= CW'(SPEED_TOL));

`ifdef ESC_STALL_DETECT_EN
    logic [DATA_WIDTH-1:0] r_stall_cnt;
    logic                  w_in_run;
    logic                  r_fault;

    assign w_in_run    = (r_state == S_RAMP) || (r_state == S_RUN);
    assign w_stall     = w_in_run && !speed_update && (stall_limit != '0) &&
                         ((CW'(r_stall_cnt) + CW'(1)) >= CW'(stall_limit));
    assign w_fault_clr = fault_clr;
    assign fault       = r_fault;

    // Cycles without speed feedback while spinning; zero outside RAMP/RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_fault <= (w_state_nxt == S_FAULT);
            if (!w_in_run || speed_update)
                r_stall_cnt <= '0;
            else if (r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + DATA_WIDTH'(1);
        end
    end
`else
    logic w_unused;
    assign w_unused    = ^{fault_clr, speed_update, stall_limit};
    assign w_stall     = 1'b0;
    // FAULT is unreachable here; recover unconditionally should it ever be seen.
    assign w_fault_clr = 1'b1;
    assign fault       = 1'b0;
`endif

    // Next-state, reference and shared dwell/tick counter.
    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_ALIGN;
            end
            S_ALIGN: begin
                if (stop)                                  w_state_nxt = S_BRAKE;
                else if (w_cnt_inc >= CW'(ALIGN_CYCLES))   w_state_nxt = S_RAMP;
                else                                       w_cnt_nxt   = DATA_WIDTH'(w_cnt_inc);
            end
            S_RAMP: begin
                if (w_stall)     w_state_nxt = S_FAULT;
                else if (stop)   w_state_nxt = S_BRAKE;
                else begin
                    w_ref_nxt = DATA_WIDTH'(w_ref_step);
                    w_cnt_nxt = w_tick ? '0 : DATA_WIDTH'(w_cnt_inc);
                    if (w_ref_step == w_tgt_x) w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_stall)                       w_state_nxt = S_FAULT;
                else if (stop)                     w_state_nxt = S_BRAKE;
                else if (target_period != r_ref)   w_state_nxt = S_RAMP;
            end
            S_BRAKE: begin
                if (w_cnt_inc >= CW'(BRAKE_CYCLES)) w_state_nxt = S_IDLE;
                else                                w_cnt_nxt   = DATA_WIDTH'(w_cnt_inc);
            end
            S_FAULT: begin
                if (w_fault_clr) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
        if (w_state_nxt == S_IDLE)  w_ref_nxt = START_PERIOD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ref      <= START_PERIOD;
            r_cnt      <= '0;
            r_pwm_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_at_speed <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ref      <= w_ref_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pwm_en   <= (w_state_nxt == S_ALIGN) || (w_state_nxt == S_RAMP) ||
                          (w_state_nxt == S_RUN);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_at_speed <= (w_state_nxt == S_RUN) && w_spd_ok;
        end
    end

    assign state            = r_state;
    assign period_reference = r_ref;
    assign pwm_en           = r_pwm_en;
    assign busy             = r_busy;
    assign at_speed         = r_at_speed;

endmodule

// File: tb/tb_esc_ramp_sequencer.sv
// Bench for esc_ramp_sequencer: directed scenarios plus randomized episodes against
// a timestamp-based behavioural model; honours ESC_STALL_DETECT_EN when defined.
module tb_esc_ramp_sequencer;

    localparam int START   = 4000;
    localparam int ALIGN_N = 1000;
    localparam int BRAKE_N = 500;
    localparam int TOL     = 8;

    logic        clk = 1'b0, reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, fault_clr = 1'b0, speed_update = 1'b0;
    logic [15:0] target_period = 16'd1000, ramp_step = 16'd500, ramp_interval = 16'd9;
    logic [15:0] period_speed = 16'd0, stall_limit = 16'd0;
    logic        pwm_en, busy, at_speed, fault;
    logic [15:0] period_reference;
    logic [2:0]  state;

    int errors = 0, checks = 0, upd_prob = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    esc_ramp_sequencer #(
        .DATA_WIDTH(16), .START_PERIOD(16'd4000), .ALIGN_CYCLES(16'd1000),
        .BRAKE_CYCLES(16'd500), .SPEED_TOL(16'd8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .fault_clr(fault_clr),
        .target_period(target_period), .ramp_step(ramp_step), .ramp_interval(ramp_interval),
        .speed_update(speed_update), .period_speed(period_speed), .stall_limit(stall_limit),
        .pwm_en(pwm_en), .period_reference(period_reference), .busy(busy),
        .at_speed(at_speed), .fault(fault), .state(state)
    );

    // Model: phase, reference, and cycle stamps of phase entry, last tick, last feedback.
    typedef struct {
        int st; int rf; int cyc; int entry; int anchor; int quiet; bit at;
    } mdl_t;
    mdl_t m;

    function automatic mdl_t reset_model();
        mdl_t r;
        r.st = 0; r.rf = START; r.cyc = 0; r.entry = 0; r.anchor = 0; r.quiet = 0; r.at = 1'b0;
        return r;
    endfunction

    function automatic mdl_t model_next(mdl_t c);
        mdl_t n = c;
        int   cyc, stp, d;
        bit   stall, run_c, run_n;
        n.cyc = c.cyc + 1;
        cyc   = n.cyc;
        run_c = (c.st == 2) || (c.st == 3);
        stall = 1'b0;
`ifdef ESC_STALL_DETECT_EN
        stall = run_c && (stall_limit != 0) && !speed_update && ((cyc - c.quiet) >= int'(stall_limit));
`endif
        case (c.st)
            0: if (start) n.st = 1;
            1: if (stop) n.st = 4; else if (cyc - c.entry >= ALIGN_N) n.st = 2;
            2: if (stall) n.st = 5;
               else if (stop) n.st = 4;
               else begin
                   if (cyc - c.anchor > int'(ramp_interval)) begin
                       stp = (ramp_step == 0) ? 1 : int'(ramp_step);
                       d   = int'(target_period) - c.rf;
                       if (d > 0) n.rf = c.rf + ((stp < d) ? stp : d);
                       else       n.rf = c.rf - ((stp < -d) ? stp : -d);
                       n.anchor = cyc;
                   end
                   if (n.rf == int'(target_period)) n.st = 3;
               end
            3: if (stall) n.st = 5;
               else if (stop) n.st = 4;
               else if (int'(target_period) != c.rf) n.st = 2;
            4: if (cyc - c.entry >= BRAKE_N) n.st = 0;
            5: if (fault_clr) n.st = 0;
            default: n.st = 0;
        endcase
        if (n.st != c.st) begin
            n.entry = cyc;
            if (n.st == 2) n.anchor = cyc;
        end
        run_n = (n.st == 2) || (n.st == 3);
        if ((run_n && !run_c) || speed_update) n.quiet = cyc;
        if (n.st == 0) n.rf = START;
        d = int'(period_speed) - int'(target_period);
        if (d < 0) d = -d;
        n.at = (n.st == 3) && (d <= TOL);
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= reset_model();
        else       m <= model_next(m);
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed value checked against both the DUT and the model.
    task automatic lit(string name, int dutv, int mdlv, int exp);
        chk(name, dutv, exp);
        chk({name, "_model"}, mdlv, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", int'(state), m.st);
            chk("period_reference", int'(period_reference), m.rf);
            chk("pwm_en", int'(pwm_en), int'(m.st >= 1 && m.st <= 3));
            chk("busy", int'(busy), int'(m.st != 0));
            chk("fault", int'(fault), int'(m.st == 5));
            chk("at_speed", int'(at_speed), int'(m.at));
        end
    end

    initial forever begin
        @(negedge clk);
        speed_update = (upd_prob > 0) && (int'($urandom_range(0, 99)) < upd_prob);
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic waitn(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; waitn(1); start = 1'b0;
    endtask

    task automatic settle();
        stop = 1'b1; fault_clr = 1'b1; waitn(1);
        stop = 1'b0; fault_clr = 1'b0; waitn(BRAKE_N + 2);
    endtask

    initial begin
        waitn(3);
        reset = 1'b0;
        cmp_en = 1'b1;
        lit("rst_state", int'(state), m.st, 0);
        lit("rst_ref", int'(period_reference), m.rf, START);
        lit("rst_pwm", int'(pwm_en), int'(m.st != 0), 0);

        // Spin-up to 1000 with 500-step ramp every 10 clocks.
        target_period = 16'd1000; ramp_step = 16'd500; ramp_interval = 16'd9;
        period_speed = 16'd1000;
        pulse_start();
        waitn(999);  lit("A_align_end", int'(state), m.st, 1);
        waitn(1);    lit("A_ramp_entry", int'(state), m.st, 2);
                     lit("A_ramp_ref0", int'(period_reference), m.rf, 4000);
        waitn(10);   lit("A_first_tick", int'(period_reference), m.rf, 3500);
        waitn(50);   lit("A_final_ref", int'(period_reference), m.rf, 1000);
                     lit("A_run", int'(state), m.st, 3);
                     lit("A_busy", int'(busy), int'(m.st != 0), 1);
        period_speed = 16'd1008; waitn(2); lit("at_speed_tol", int'(at_speed), int'(m.at), 1);
        period_speed = 16'd1009; waitn(2); lit("at_speed_out", int'(at_speed), int'(m.at), 0);
        target_period = 16'd1200; waitn(11);
        lit("A_up_small", int'(period_reference), m.rf, 1200);
        target_period = 16'd2000; waitn(11);
        lit("A_up_1700", int'(period_reference), m.rf, 1700);
        waitn(10);   lit("A_up_2000", int'(period_reference), m.rf, 2000);
                     lit("A_up_run", int'(state), m.st, 3);
        stop = 1'b1; waitn(1); stop = 1'b0;
        lit("A_brake", int'(state), m.st, 4);
        lit("A_brake_pwm", int'(pwm_en), int'(m.st >= 1 && m.st <= 3), 0);
        waitn(499);  lit("A_brake_end", int'(state), m.st, 4);
        waitn(1);    lit("A_idle", int'(state), m.st, 0);

        // Down-ramp without overshoot, then stop mid-ramp with start during BRAKE.
        target_period = 16'd1200;
        pulse_start();
        waitn(1050); lit("B_1500", int'(period_reference), m.rf, 1500);
        waitn(10);   lit("B_1200", int'(period_reference), m.rf, 1200);
                     lit("B_run", int'(state), m.st, 3);
        target_period = 16'd4000;
        waitn(15);   stop = 1'b1; waitn(1); stop = 1'b0;
        lit("B_brake", int'(state), m.st, 4);
        lit("B_brake_ref", int'(period_reference), m.rf, 1700);
        lit("B_brake_pwm", int'(pwm_en), int'(m.st >= 1 && m.st <= 3), 0);
        waitn(80);   pulse_start();
        waitn(418);  lit("B_brake_hold", int'(state), m.st, 4);
        waitn(1);    lit("B_idle", int'(state), m.st, 0);
                     lit("B_idle_ref", int'(period_reference), m.rf, 4000);

        // Stall watchdog with no speed feedback.
        stall_limit = 16'd200; target_period = 16'd4000; period_speed = 16'd4000;
        pulse_start();
        waitn(1000); lit("C_ramp", int'(state), m.st, 2);
        waitn(1);    lit("C_run", int'(state), m.st, 3);
        waitn(198);  lit("C_pre_stall", int'(state), m.st, 3);
        waitn(1);
`ifdef ESC_STALL_DETECT_EN
        lit("C_fault", int'(state), m.st, 5);
        lit("C_fault_out", int'(fault), int'(m.st == 5), 1);
        lit("C_fault_pwm", int'(pwm_en), int'(m.st >= 1 && m.st <= 3), 0);
        fault_clr = 1'b1; waitn(1); fault_clr = 1'b0;
        lit("C_clr_idle", int'(state), m.st, 0);
`else
        lit("C_no_fault", int'(state), m.st, 3);
        lit("C_no_fault_out", int'(fault), int'(m.st == 5), 0);
`endif
        settle();

        // Stall and stop in the same cycle.
        pulse_start();
        waitn(1199); stop = 1'b1; waitn(1); stop = 1'b0;
`ifdef ESC_STALL_DETECT_EN
        lit("D_stall_wins", int'(state), m.st, 5);
`else
        lit("D_stop_only", int'(state), m.st, 4);
`endif
        settle();

        // Asynchronous reset mid-ALIGN.
        stall_limit = 16'd0;
        pulse_start();
        waitn(300);
        #2 reset = 1'b1;
        #1;
        lit("E_rst_state", int'(state), m.st, 0);
        lit("E_rst_ref", int'(period_reference), m.rf, 4000);
        lit("E_rst_pwm", int'(pwm_en), int'(m.st >= 1 && m.st <= 3), 0);
        lit("E_rst_busy", int'(busy), int'(m.st != 0), 0);
        waitn(1);
        reset = 1'b0;

        // Randomized episodes.
        for (int e = 0; e < 12; e++) begin
            target_period = 16'($urandom_range(500, 6000));
            ramp_step     = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 700));
            ramp_interval = 16'($urandom_range(0, 12));
            stall_limit   = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(30, 400));
            upd_prob      = int'($urandom_range(0, 3)) * 2;
            period_speed  = target_period;
            pulse_start();
            for (int c = 0; c < 2500; c++) begin
                start     = ($urandom_range(0, 199) == 0);
                stop      = ($urandom_range(0, 799) == 0);
                fault_clr = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 299) == 0) target_period = 16'($urandom_range(500, 6000));
                if ($urandom_range(0, 7) == 0)
                    period_speed = 16'(int'(target_period) + int'($urandom_range(0, 24)) - 12);
                waitn(1);
            end
            start = 1'b0;
            settle();
        end
        upd_prob = 0;
        waitn(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
